inv_key_schedule: RTL and testbench
===================================

Name: inv_key_schedule

Overview:
- AES-128 round-key generator and store that feeds the decryption datapath.
- Expands a 128-bit cipher key into round keys 0..10, one round key per clock, and holds all 11 in a register file.
- Presents them in reverse order (10 down to 0), one per request, to the inverse-round stage's key input.
- Key is retained, so consecutive ciphertext blocks reuse one expansion.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  single-cycle pulse; capture cipher_key and start expansion
- cipher_key  input  [0:127]  cipher key; bit 0 = MSB of byte 0, word w = bits 32w..32w+31
- rk_req  input  1  consumer took current rk_out; advance to next lower round key
- rk_out  output  [0:127]  current round key
- rk_idx  output  4  round index of rk_out (10..0)
- rk_valid  output  1  rk_out/rk_idx valid
- rk_last  output  1  high when rk_valid and rk_idx==0
- busy  output  1  expansion in progress

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE; all outputs 0 (rk_out=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0).
  - Register file contents don't-care.
- FSM states: IDLE, EXPAND, SERVE.
- IDLE:
  - key_load -> write cipher_key to slot 0, round counter r=1, go to EXPAND, busy=1 next cycle.
  - rk_req ignored.
- EXPAND: each cycle computes round key r from round key r-1 and writes slot r.
  - t = SubWord(RotWord(w3)) XOR {Rcon[r],00,00,00}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Four forward AES S-box lookups per cycle; Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - After r=10 is written, go to SERVE with rk_idx=10, rk_valid=1, busy=0.
- Latency: key_load sampled on edge E0; slots 1..10 written on E1..E10; rk_valid high after E10, i.e. 10 cycles after load capture.
- SERVE:
  - rk_out = slot[rk_idx], registered; must be stable while rk_req is low.
  - rk_req with rk_idx>0 -> rk_idx decrements next edge.
  - rk_req with rk_idx==0 -> rk_idx wraps to 10, rk_valid stays 1 (next block, same key).
  - rk_last = rk_valid && rk_idx==0.
- key_load in EXPAND or SERVE:
  - Restarts: slot 0 overwritten, r=1, EXPAND, rk_valid=0 next cycle.
  - Same-cycle rk_req is ignored.
- rk_req outside SERVE: ignored, no state change.
- Reset mid-expansion or mid-serve: immediate return to IDLE with outputs 0; no partial key exposed.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c -> rk_valid rises exactly 10 cycles after load capture.
  - rk_idx=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - busy high during the 10 expand cycles only.
- Same key, 10 rk_req pulses, then 1 more:
  - idx 1 gives a0fafe1788542cb123a339392a6c7605.
  - idx 0 gives the original key, with rk_last=1.
  - The 11th request returns idx 10, same value as before, rk_valid never dropping.
- Key 000102030405060708090a0b0c0d0e0f -> rk_idx=10 key 13111d7fe3944a17f307a78b4d2b30c5.
- rk_req held low 20 cycles in SERVE -> rk_out/rk_idx unchanged. rk_req pulsed in IDLE/EXPAND -> no effect.
- Second key_load at EXPAND cycle 5 with key 000102..0f -> rk_valid stays 0 until 10 cycles after the second load, then 13111d7f... appears.
- rst_n asserted in SERVE with rk_idx=4 -> rk_valid, rk_out, rk_idx go 0 immediately, without waiting for a clock edge.
  - Subsequent load completes normally.

Source files
------------

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the AES-128 inverse key schedule and its user.
// The master side loads the cipher key and requests round keys; the slave
// side (the key schedule) presents round keys in descending round order.
interface inv_key_schedule_if;
    logic           key_load;
    logic [0:127]   cipher_key;
    logic           rk_req;
    logic [0:127]   rk_out;
    logic [3:0]     rk_idx;
    logic           rk_valid;
    logic           rk_last;
    logic           busy;

    modport master (
        output key_load,
        output cipher_key,
        output rk_req,
        input  rk_out,
        input  rk_idx,
        input  rk_valid,
        input  rk_last,
        input  busy
    );

    modport slave (
        input  key_load,
        input  cipher_key,
        input  rk_req,
        output rk_out,
        output rk_idx,
        output rk_valid,
        output rk_last,
        output busy
    );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule.
// Expands a cipher key into round keys 0..NR (one per clock) into a local
// register file, then serves them from round NR down to round 0, one per
// request, wrapping back to round NR so later blocks reuse the expansion.
// All outputs are registered; the register file itself is never reset.
module inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    inv_key_schedule_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SERVE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    // Forward AES S-box, byte n at bits 8n..8n+7.
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One step of the AES-128 key expansion: round key r from round key r-1.
    function automatic logic [0:127] next_round_key(input logic [0:127] k,
                                                    input logic [3:0]   r);
        logic [0:31] w0, w1, w2, w3, t;
        w0 = k[0:31];
        w1 = k[32:63];
        w2 = k[64:95];
        w3 = k[96:127];
        // RotWord then SubWord on w3, then fold in the round constant.
        t  = {sbox(w3[8:15]), sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])};
        t  = t ^ {rcon(r), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t         state, state_nxt;
    logic [3:0]     rnd_q, rnd_nxt;
    logic [3:0]     rk_idx_q, rk_idx_nxt;
    logic           rk_valid_q, rk_valid_nxt;
    logic           rk_last_q, rk_last_nxt;
    logic           busy_q, busy_nxt;
    logic [0:127]   rk_out_q, rk_out_nxt;

    logic [0:127]   wk;                 // round key r-1 during expansion
    logic [0:127]   exp_key;            // round key r
    logic [0:127]   rf [0:NR];

    assign exp_key = next_round_key(wk, rnd_q);

    // State and output registers; reset clears everything the user can see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rnd_q      <= 4'd0;
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            rk_out_q   <= '0;
        end else begin
            state      <= state_nxt;
            rnd_q      <= rnd_nxt;
            rk_idx_q   <= rk_idx_nxt;
            rk_valid_q <= rk_valid_nxt;
            rk_last_q  <= rk_last_nxt;
            busy_q     <= busy_nxt;
            rk_out_q   <= rk_out_nxt;
        end
    end

    // Next-state and next-output logic; key_load restarts from any state.
    always_comb begin
        state_nxt    = state;
        rnd_nxt      = rnd_q;
        rk_idx_nxt   = rk_idx_q;
        rk_valid_nxt = rk_valid_q;
        rk_last_nxt  = rk_last_q;
        busy_nxt     = busy_q;
        rk_out_nxt   = rk_out_q;

        if (bus.key_load) begin
            state_nxt    = EXPAND;
            rnd_nxt      = 4'd1;
            busy_nxt     = 1'b1;
            rk_valid_nxt = 1'b0;
            rk_last_nxt  = 1'b0;
            rk_idx_nxt   = 4'd0;
            rk_out_nxt   = '0;
        end else begin
            case (state)
                EXPAND: begin
                    if (rnd_q == LAST_RND) begin
                        // Last round key bypasses the register file so it
                        // is presented on the same edge it is written.
                        state_nxt    = SERVE;
                        busy_nxt     = 1'b0;
                        rk_valid_nxt = 1'b1;
                        rk_idx_nxt   = LAST_RND;
                        rk_last_nxt  = 1'b0;
                        rk_out_nxt   = exp_key;
                    end else begin
                        rnd_nxt = rnd_q + 4'd1;
                    end
                end
                SERVE: begin
                    if (bus.rk_req) begin
                        rk_idx_nxt  = (rk_idx_q == 4'd0) ? LAST_RND
                                                         : rk_idx_q - 4'd1;
                        rk_last_nxt = (rk_idx_nxt == 4'd0);
                        rk_out_nxt  = rf[rk_idx_nxt];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Key expansion datapath: slot 0 on load, slot r on each expand cycle.
    always_ff @(posedge clk) begin
        if (bus.key_load) begin
            rf[0] <= bus.cipher_key;
            wk    <= bus.cipher_key;
        end else if (state == EXPAND) begin
            rf[rnd_q] <= exp_key;
            wk        <= exp_key;
        end
    end

    assign bus.rk_out   = rk_out_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_last  = rk_last_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule using FIPS-197 keys.
module tb_inv_key_schedule;

    localparam logic [0:127] KEY1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] KEY1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] KEY1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inv_key_schedule_if bus ();

    inv_key_schedule #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [0:127] k);
        bus.cipher_key = k;
        bus.key_load   = 1'b1;
        tick();
        bus.key_load   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        bus.key_load   = 1'b0;
        bus.rk_req     = 1'b0;
        bus.cipher_key = '0;
        tick();
        tick();
        checks++;
        if ({bus.rk_valid, bus.rk_last, bus.busy, bus.rk_idx} !== 7'd0 || bus.rk_out !== 128'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b busy=%b idx=%0d out=%h required all zero",
                     bus.rk_valid, bus.rk_last, bus.busy, bus.rk_idx, bus.rk_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_req;
        bus.rk_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.rk_valid, bus.busy, bus.rk_idx} !== 6'd0) begin
                errors++;
                $display("FAIL idle_req: valid=%b busy=%b idx=%0d required 0 0 0",
                         bus.rk_valid, bus.busy, bus.rk_idx);
            end
        end
        bus.rk_req = 1'b0;
    endtask

    task automatic test_load_latency;
        int busy_cycles;
        load_key(KEY1);
        busy_cycles = 0;
        for (int e = 1; e <= 10; e++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            checks++;
            if (bus.rk_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early_valid: edge %0d valid=%b required 0", e, bus.rk_valid);
            end
            tick();
        end
        checks++;
        if (busy_cycles !== 10) begin
            errors++;
            $display("FAIL busy_cycles: got %0d required 10", busy_cycles);
        end
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b0 || bus.rk_idx !== 4'd10) begin
            errors++;
            $display("FAIL latency_done: valid=%b busy=%b idx=%0d required 1 0 10",
                     bus.rk_valid, bus.busy, bus.rk_idx);
        end
        checks++;
        if (bus.rk_out !== KEY1_R10) begin
            errors++;
            $display("FAIL key1_round10: got %h required %h", bus.rk_out, KEY1_R10);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_idx;
        bus.rk_req = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            exp_idx = (n == 11) ? 4'd10 : 4'(10 - n);
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_idx !== exp_idx) begin
                errors++;
                $display("FAIL serve_idx: request %0d valid=%b idx=%0d required 1 %0d",
                         n, bus.rk_valid, bus.rk_idx, exp_idx);
            end
            checks++;
            if (bus.rk_last !== (exp_idx == 4'd0)) begin
                errors++;
                $display("FAIL serve_last: request %0d last=%b required %b",
                         n, bus.rk_last, (exp_idx == 4'd0));
            end
            if (exp_idx == 4'd1) begin
                checks++;
                if (bus.rk_out !== KEY1_R1) begin
                    errors++;
                    $display("FAIL key1_round1: got %h required %h", bus.rk_out, KEY1_R1);
                end
            end
            if (exp_idx == 4'd0) begin
                checks++;
                if (bus.rk_out !== KEY1) begin
                    errors++;
                    $display("FAIL key1_round0: got %h required %h", bus.rk_out, KEY1);
                end
            end
            if (n == 11) begin
                checks++;
                if (bus.rk_out !== KEY1_R10) begin
                    errors++;
                    $display("FAIL wrap_round10: got %h required %h", bus.rk_out, KEY1_R10);
                end
            end
        end
        bus.rk_req = 1'b0;
    endtask

    task automatic test_hold;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.rk_out !== KEY1_R10 || bus.rk_idx !== 4'd10 || bus.rk_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold: cycle %0d idx=%0d valid=%b out=%h required 10 1 %h",
                         i, bus.rk_idx, bus.rk_valid, bus.rk_out, KEY1_R10);
            end
        end
    endtask

    task automatic test_expand_req;
        load_key(KEY2);
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_from_serve: valid=%b busy=%b required 0 1", bus.rk_valid, bus.busy);
        end
        for (int e = 1; e <= 10; e++) begin
            bus.rk_req = (e >= 2 && e <= 8);
            tick();
        end
        bus.rk_req = 1'b0;
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd10 || bus.rk_out !== KEY2_R10) begin
            errors++;
            $display("FAIL key2_round10: valid=%b idx=%0d out=%h required 1 10 %h",
                     bus.rk_valid, bus.rk_idx, bus.rk_out, KEY2_R10);
        end
    endtask

    task automatic test_restart;
        load_key(KEY1);
        for (int e = 1; e <= 4; e++) tick();
        bus.rk_req = 1'b1;
        load_key(KEY2);
        bus.rk_req = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            checks++;
            if (bus.rk_valid !== 1'b0) begin
                errors++;
                $display("FAIL restart_early_valid: edge %0d valid=%b required 0", e, bus.rk_valid);
            end
            tick();
        end
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd10 || bus.rk_out !== KEY2_R10) begin
            errors++;
            $display("FAIL restart_result: valid=%b idx=%0d out=%h required 1 10 %h",
                     bus.rk_valid, bus.rk_idx, bus.rk_out, KEY2_R10);
        end
    endtask

    task automatic test_async_reset;
        bus.rk_req = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        bus.rk_req = 1'b0;
        checks++;
        if (bus.rk_idx !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset_idx: got %0d required 4", bus.rk_idx);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.rk_idx !== 4'd0 || bus.rk_out !== 128'd0 || bus.rk_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b idx=%0d last=%b out=%h required all zero",
                     bus.rk_valid, bus.rk_idx, bus.rk_last, bus.rk_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        load_key(KEY1);
        for (int e = 1; e <= 10; e++) tick();
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd10 || bus.rk_out !== KEY1_R10) begin
            errors++;
            $display("FAIL post_reset_load: valid=%b idx=%0d out=%h required 1 10 %h",
                     bus.rk_valid, bus.rk_idx, bus.rk_out, KEY1_R10);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle_req();
        test_load_latency();
        test_back_to_back();
        test_hold();
        test_expand_req();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
